dmem_arbiter: RTL and testbench

//   Round-robin arbiter sharing the single-port data memory (DataMem) between NREQ requesters,
//   e.g. CPU load/store path and a debug/loader port. Serialises word accesses, drives the

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ requesters.
// Each access takes IDLE -> ACCESS -> DONE, with a one-cycle ack to the served requester.
module dmem_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   we_i,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] wdata_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   err_o,
    output logic [DW-1:0]     rdata_o,
    output logic              busy_o,
    output logic [AW-1:0]     mem_a,
    output logic [DW-1:0]     mem_din,
    output logic              mem_we,
    input  logic [DW-1:0]     mem_dout
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state_reg;
    logic [GW-1:0]   ptr_reg;
    logic [GW-1:0]   gnt_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic            we_reg;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    logic [GW-1:0]   win_next;
    logic [GW:0]     idx;
    logic            found;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            win_we;
    logic            misaligned;
    logic [NREQ-1:0] gnt_onehot;
    logic [GW-1:0]   ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*AW +: AW];
            assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
        end
    endgenerate

    // First requester found scanning upward from ptr, wrapping modulo NREQ.
    always_comb begin
        win_next = ptr_reg;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_reg} + (GW+1)'(k);
            if (idx >= (GW+1)'(NREQ))
                idx = idx - (GW+1)'(NREQ);
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                win_next = idx[GW-1:0];
            end
        end
    end

    assign win_addr   = addr_arr[win_next];
    assign win_wdata  = wdata_arr[win_next];
    assign win_we     = we_i[win_next];
    assign misaligned = |addr_reg[1:0];
    assign gnt_onehot = NREQ'(1) << gnt_reg;
    assign ptr_next   = (gnt_reg == GW'(NREQ-1)) ? '0 : gnt_reg + GW'(1);

    // Memory address/data simply follow the latched request; only mem_we gates the write.
    assign mem_a   = addr_reg;
    assign mem_din = wdata_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            ack_o     <= '0;
            err_o     <= '0;
            rdata_o   <= '0;
            busy_o    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_i) begin
                        gnt_reg   <= win_next;
                        addr_reg  <= win_addr;
                        wdata_reg <= win_wdata;
                        we_reg    <= win_we;
                        mem_we    <= win_we && (win_addr[1:0] == 2'b00);
                        busy_o    <= 1'b1;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we    <= 1'b0;
                    ack_o     <= gnt_onehot;
                    err_o     <= misaligned ? gnt_onehot : '0;
                    if (!we_reg && !misaligned)
                        rdata_o <= mem_dout;
                    ptr_reg   <= ptr_next;
                    state_reg <= DONE;
                end
                DONE: begin
                    ack_o     <= '0;
                    err_o     <= '0;
                    busy_o    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single transactions against a behavioural DataMem,
// then hand-written sequences for reset mid-access, contention and held requests.
module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              clk;
    logic              clrn;
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   we_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] wdata_i;
    logic [NREQ-1:0]   ack_o;
    logic [NREQ-1:0]   err_o;
    logic [DW-1:0]     rdata_o;
    logic              busy_o;
    logic [AW-1:0]     mem_a;
    logic [DW-1:0]     mem_din;
    logic              mem_we;
    logic [DW-1:0]     mem_dout;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .busy_o   (busy_o),
        .mem_a    (mem_a),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    // DataMem: async read, posedge write, word index addr[6:2].
    logic [31:0] dmem [32];
    assign mem_dout = dmem[mem_a[6:2]];
    always @(posedge clk) begin
        if (mem_we)
            dmem[mem_a[6:2]] <= mem_din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          wecnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int lat, wecnt, cyc, prev, nack;
        logic got;
        logic [1:0]  exp_ack [4];
        logic [31:0] exp_rd  [4];

        for (int i = 0; i < 32; i++) dmem[i] = 32'h100 + i;
        dmem[20] = 32'h0000_00a3;
        dmem[21] = 32'h0000_0027;
        dmem[22] = 32'h0000_0079;

        //          req    we     a0     a1     d0            d1            ack    err    rdata         wecnt
        tbl[0]  = '{2'b01, 2'b00, 32'h50, 32'h0,  32'h0,        32'h0,        2'b01, 2'b00, 32'h0000_00a3, 0};
        tbl[1]  = '{2'b10, 2'b10, 32'h0,  32'h60, 32'h0,        32'h258,      2'b10, 2'b00, 32'h0000_00a3, 1};
        tbl[2]  = '{2'b10, 2'b00, 32'h0,  32'h60, 32'h0,        32'h0,        2'b10, 2'b00, 32'h0000_0258, 0};
        tbl[3]  = '{2'b01, 2'b01, 32'h52, 32'h0,  32'hdead_beef, 32'h0,       2'b01, 2'b01, 32'h0000_0258, 0};
        tbl[4]  = '{2'b01, 2'b00, 32'h50, 32'h0,  32'h0,        32'h0,        2'b01, 2'b00, 32'h0000_00a3, 0};
        tbl[5]  = '{2'b10, 2'b00, 32'h0,  32'h61, 32'h0,        32'h0,        2'b10, 2'b10, 32'h0000_00a3, 0};
        tbl[6]  = '{2'b01, 2'b01, 32'h7c, 32'h0,  32'h1234_5678, 32'h0,       2'b01, 2'b00, 32'h0000_00a3, 1};
        tbl[7]  = '{2'b10, 2'b00, 32'h0,  32'h7c, 32'h0,        32'h0,        2'b10, 2'b00, 32'h1234_5678, 0};
        tbl[8]  = '{2'b11, 2'b00, 32'h54, 32'h58, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0000_0027, 0};
        tbl[9]  = '{2'b11, 2'b00, 32'h54, 32'h58, 32'h0,        32'h0,        2'b10, 2'b00, 32'h0000_0079, 0};
        tbl[10] = '{2'b01, 2'b00, 32'h50, 32'h0,  32'h0,        32'h0,        2'b01, 2'b00, 32'h0000_00a3, 0};

        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        clrn = 1'b0;
        #3;
        check("reset ack",   32'(ack_o),   32'h0);
        check("reset err",   32'(err_o),   32'h0);
        check("reset rdata", rdata_o,      32'h0);
        check("reset busy",  32'(busy_o),  32'h0);
        check("reset mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req_i   = tbl[i].req;
            we_i    = tbl[i].we;
            addr_i  = {tbl[i].a1, tbl[i].a0};
            wdata_i = {tbl[i].d1, tbl[i].d0};
            lat = 0; wecnt = 0; got = 1'b0;
            while (!got && lat < 10) begin
                @(negedge clk);
                lat++;
                if (mem_we) wecnt++;
                if (ack_o != '0) got = 1'b1;
            end
            req_i = '0;
            check($sformatf("v%0d latency", i), 32'(lat),   32'd2);
            check($sformatf("v%0d ack", i),     32'(ack_o), 32'(tbl[i].ack));
            check($sformatf("v%0d err", i),     32'(err_o), 32'(tbl[i].err));
            check($sformatf("v%0d rdata", i),   rdata_o,    tbl[i].rdata);
            check($sformatf("v%0d we_cycles", i), 32'(wecnt), 32'(tbl[i].wecnt));
            @(negedge clk);
            check($sformatf("v%0d ack cleared", i), 32'(ack_o), 32'h0);
        end
        check("misaligned write left word 0x50", dmem[20], 32'h0000_00a3);

        // Reset during ACCESS of a read: pointer is 1 here, so requester 1 is in flight.
        @(negedge clk);
        req_i = 2'b11; we_i = 2'b00; addr_i = {32'h58, 32'h54};
        @(negedge clk);
        check("pre-reset busy", 32'(busy_o), 32'h1);
        #2;
        clrn = 1'b0;
        #1;
        check("async reset ack",    32'(ack_o),  32'h0);
        check("async reset busy",   32'(busy_o), 32'h0);
        check("async reset mem_we", 32'(mem_we), 32'h0);
        check("async reset rdata",  rdata_o,     32'h0);
        check("async reset mem_a",  mem_a,       32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // Contention with both requests held: 0 first, then alternating.
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rd  = '{32'h27, 32'h79, 32'h27, 32'h79};
        cyc = 0; prev = 0; nack = 0;
        while (nack < 4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack_o != '0) begin
                check($sformatf("contend ack%0d", nack),   32'(ack_o), 32'(exp_ack[nack]));
                check($sformatf("contend rdata%0d", nack), rdata_o,    exp_rd[nack]);
                check($sformatf("contend gap%0d", nack),   32'(cyc - prev), (nack == 0) ? 32'd2 : 32'd3);
                prev = cyc;
                nack++;
            end
        end
        check("contend ack count", 32'(nack), 32'd4);

        // Only requester 0 held high from the ack cycle on: one ack every 3 cycles.
        req_i = 2'b01;
        cyc = 0; prev = 0; nack = 0;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (ack_o != '0) begin
                check($sformatf("held ack%0d", nack),   32'(ack_o), 32'h1);
                check($sformatf("held gap%0d", nack),   32'(cyc - prev), 32'd3);
                check($sformatf("held rdata%0d", nack), rdata_o, 32'h27);
                prev = cyc;
                nack++;
            end
        end
        check("held ack count", 32'(nack), 32'd4);
        req_i = '0;
        repeat (3) @(negedge clk);
        check("final busy", 32'(busy_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
